// File: rtl/alu1_serial_seq.sv
// Bit-serial sequencer that drives one external 1-bit ALU slice through a full
// WIDTH-bit operation, LSB first, and reports result, carry, overflow and zero.
module alu1_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic             op_error,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [2:0]       slice_ctl,
    input  logic             slice_out,
    input  logic             slice_cout,
    output logic [1:0]       dbg_state
);

    // Handshake: a request is taken on a rising edge where start=1 and ready=1.
    // start while ready=0 is dropped, never queued; done pulses once per accepted op.

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             op_error_q, op_error_d;

    logic             in_run;
    logic             in_done;
    logic             arith;
    logic             op_valid;
    logic             live_carry;
    logic             live_ovf;
    logic             live_zero;

    assign in_run     = (state_q == S_RUN);
    assign in_done    = (state_q == S_DONE);
    assign arith      = ~op_q[2];
    assign op_valid   = op[2] | op[1];

    // Flags for the finished op: carry_q holds the MSB carry-out after the last bit.
    assign live_carry = arith & carry_q;
    assign live_ovf   = arith & (cin_msb_q ^ carry_q);
    assign live_zero  = (acc_q == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            carry_q    <= 1'b0;
            cin_msb_q  <= 1'b0;
            acc_q      <= '0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            op_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            carry_q    <= carry_d;
            cin_msb_q  <= cin_msb_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            op_error_q <= op_error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        carry_d    = carry_q;
        cin_msb_d  = cin_msb_q;
        acc_d      = acc_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        op_error_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_valid) begin
                        state_d = S_RUN;
                        a_d     = a_in;
                        b_d     = b_in;
                        op_d    = op;
                        idx_d   = '0;
                        carry_d = op[0] & ~op[2];
                        acc_d   = '0;
                    end else begin
                        op_error_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                acc_d[idx_q] = slice_out;
                carry_d      = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cin_msb_d = slice_cin;
                    state_d   = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                // Capture the finished values so they stay visible in IDLE.
                state_d    = S_IDLE;
                result_d   = acc_q;
                carryout_d = live_carry;
                overflow_d = live_ovf;
                zero_d     = live_zero;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = in_done;
    assign op_error  = op_error_q;
    assign result    = in_done ? acc_q      : result_q;
    assign carryout  = in_done ? live_carry : carryout_q;
    assign overflow  = in_done ? live_ovf   : overflow_q;
    assign zero      = in_done ? live_zero  : zero_q;

    assign slice_a   = in_run & a_q[idx_q];
    assign slice_b   = in_run & b_q[idx_q];
    assign slice_cin = in_run & arith & carry_q;
    assign slice_ctl = op_q;
    assign dbg_state = state_q;

endmodule
